// File: rtl/nsa_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encodings and
// the nibble width handled by the single 4-bit adder slice.
package nsa_pkg;

  // FSM state encodings (2-bit)
  localparam logic [1:0] NSA_IDLE = 2'd0;
  localparam logic [1:0] NSA_RUN  = 2'd1;
  localparam logic [1:0] NSA_DONE = 2'd2;

  // Bits processed per clock by the adder slice
  localparam int NSA_NIB = 4;

  // Nibble counter width: clog2(nibbles), never narrower than one bit
  function automatic int nsa_cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// cla4: purely combinational 4-bit carry-lookahead adder slice.
// All four internal carries come from generate/propagate terms, so the
// carry-out does not ripple through the sum bits.
module cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  // Per-bit generate and propagate
  always_comb begin
    w_g = i_a & i_b;
    w_p = i_a ^ i_b;
  end

  // Lookahead carries, each a flat sum of products of g/p and carry-in
  always_comb begin
    w_c[0] = i_ci;
    w_c[1] = w_g[0] | (w_p[0] & i_ci);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & i_ci);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);
  end

  // Sum bits and carry-out
  always_comb begin
    o_s  = w_p ^ w_c[3:0];
    o_co = w_c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one cla4 slice over
// WIDTH/4 clocks, least-significant nibble first. The inter-nibble carry
// is registered, so the critical path is one cla4 plus register setup.
// Optional feature macro: NSA_SUB_EN adds the op_sub port (A - B mode).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4, at least 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef NSA_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int N     = WIDTH / NSA_NIB;
  localparam int CNT_W = nsa_cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_co;

  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_load;
  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic [WIDTH-1:0] w_s_shift;

`ifdef NSA_SUB_EN
  assign w_sub = op_sub;
`else
  assign w_sub = 1'b0;
`endif

  // Single shared adder slice working on the current low nibble
  cla4 u_cla4 (
    .i_a  (r_a[3:0]),
    .i_b  (r_b[3:0]),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_cout)
  );

  // Accept decode and operand conditioning (subtract = A + ~B + 1)
  always_comb begin
    w_accept     = start && ((r_state == NSA_IDLE) || (r_state == NSA_DONE));
    w_last       = (r_cnt == CNT_LAST);
    w_b_load     = w_sub ? ~b : b;
    w_carry_load = w_sub ? 1'b1 : ci;
  end

  // Nibble-wise right shifts: operands drain zeros in at the top, the sum
  // register takes the fresh cla4 nibble at the top
  for (genvar gi = 0; gi < N; gi++) begin : g_shift
    if (gi == N - 1) begin : g_top
      assign w_a_shift[gi*NSA_NIB +: NSA_NIB] = '0;
      assign w_b_shift[gi*NSA_NIB +: NSA_NIB] = '0;
      assign w_s_shift[gi*NSA_NIB +: NSA_NIB] = w_sum;
    end else begin : g_mid
      assign w_a_shift[gi*NSA_NIB +: NSA_NIB] = r_a[(gi+1)*NSA_NIB +: NSA_NIB];
      assign w_b_shift[gi*NSA_NIB +: NSA_NIB] = r_b[(gi+1)*NSA_NIB +: NSA_NIB];
      assign w_s_shift[gi*NSA_NIB +: NSA_NIB] = r_s[(gi+1)*NSA_NIB +: NSA_NIB];
    end
  end

  // Control FSM plus datapath registers; reset discards any in-flight work
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= NSA_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
    end else begin
      case (r_state)
        NSA_IDLE, NSA_DONE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_carry_load;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_state <= NSA_RUN;
          end else begin
            r_state <= NSA_IDLE;
          end
        end
        NSA_RUN: begin
          r_carry <= w_cout;
          r_s     <= w_s_shift;
          r_a     <= w_a_shift;
          r_b     <= w_b_shift;
          r_cnt   <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_co    <= w_cout;
            r_state <= NSA_DONE;
          end
        end
        default: begin
          r_state <= NSA_IDLE;
        end
      endcase
    end
  end

  // Status and result outputs decoded straight from registers
  always_comb begin
    busy = (r_state == NSA_RUN);
    done = (r_state == NSA_DONE);
    s    = r_s;
    co   = r_co;
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16: a vector table
// of additions plus directed sequences for reset, hold, back-to-back and
// mid-operation reset. Subtract vectors are exercised when NSA_SUB_EN is set.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         op_sub;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic [W-1:0] exp_s;
    logic         exp_co;
  } vec_t;

  vec_t vecs[$];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ci      (ci),
`ifdef NSA_SUB_EN
    .op_sub  (op_sub),
`endif
    .busy    (busy),
    .done    (done),
    .s       (s),
    .co      (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (at negedges) until done is seen; returns negedges waited
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Launch one operation from a negedge; returns with done high (or timeout)
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vci, input logic vsub,
                        output int lat, output int busy_cnt);
    start = 1'b1; a = va; b = vb; ci = vci; op_sub = vsub;
    @(negedge clk);
    start = 1'b0; a = 'x; b = 'x; ci = 1'bx; op_sub = 1'b0;
    wait_done(lat, busy_cnt);
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0; op_sub = 1'b0;

    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0});
    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0});
`ifdef NSA_SUB_EN
    vecs.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s", 32'(s), 32'h0);
    check("rst_co", 32'(co), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d_outs", i), {14'b0, busy, done, s}, 32'h0);
      check($sformatf("idle%0d_co", i), 32'(co), 32'h0);
    end

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, lat, bc);
      $display("[TB] vec %0d: a=%h b=%h ci=%0d sub=%0d -> s=%h co=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, s, co, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd4);
      check($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d_co", i), 32'(co), 32'(vecs[i].exp_co));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
      check($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'h0);
    end

    // Carry-in result holds through idle cycles
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat, bc);
    $display("[TB] hold: s=%h co=%0d", s, co);
    check("hold_done_s", 32'(s), 32'h5556);
    repeat (3) @(negedge clk);
    check("hold_s", 32'(s), 32'h5556);
    check("hold_co", 32'(co), 32'h0);
    check("hold_done", 32'(done), 32'h0);

    // Back-to-back with an ignored mid-RUN start
    start = 1'b1; a = 16'h1111; b = 16'h2222; ci = 1'b0;
    @(negedge clk);                          // after E0
    start = 1'b0;
    @(negedge clk);                          // after E1
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
    @(negedge clk);                          // after E2, start seen at E2
    start = 1'b0;
    wait_done(lat, bc);
    $display("[TB] b2b first: s=%h co=%0d lat=%0d", s, co, lat);
    check("b2b_first_lat", 32'(lat), 32'd2);
    check("b2b_first_s", 32'(s), 32'h3333);
    check("b2b_first_co", 32'(co), 32'h0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat, bc);
    $display("[TB] b2b second: s=%h co=%0d gap=%0d", s, co, lat + 1);
    check("b2b_second_gap", 32'(lat + 1), 32'd5);
    check("b2b_second_s", 32'(s), 32'h0000);
    check("b2b_second_co", 32'(co), 32'h1);
    @(negedge clk);

    // Reset two cycles into an operation
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_s", 32'(s), 32'h0);
    check("midrst_co", 32'(co), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    $display("[TB] midrst: activity cycles after reset=%0d", done_seen);
    check("midrst_no_done", 32'(done_seen), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, bc);
    $display("[TB] post-reset: s=%h co=%0d lat=%0d", s, co, lat);
    check("postrst_lat", 32'(lat), 32'd4);
    check("postrst_s", 32'(s), 32'h0100);
    check("postrst_co", 32'(co), 32'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that time-multiplexes one `cla4` instance across the operand, one nibble per clock, least-significant nibble first. It sits around the 4-bit carry-lookahead adder as its operand-feeding and result-collecting stage. It latches operands on a start pulse, chains the `cla4` carry-out through a carry register, assembles the sum in a shift register, and reports completion with a one-cycle `done`. This lets wide additions reuse a single 4-bit adder at the cost of WIDTH/4 cycles of latency.

## Interface
- `WIDTH`, 16: operand/sum width; must be a multiple of 4, minimum 4. N = WIDTH/4 nibbles.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a new addition; sampled only in IDLE or DONE.
- `a` input WIDTH: operand A; latched on accepted start.
- `b` input WIDTH: operand B; latched on accepted start.
- `ci` input 1: carry-in; latched on accepted start.
- `op_sub` input 1: present only with `NSA_SUB_EN`; 1 = A − B; latched on accepted start.
- `busy` output 1: high while in RUN.
- `done` output 1: high for exactly one cycle (DONE state).
- `s` output WIDTH: sum register; holds last result until next accepted start.
- `co` output 1: final carry-out; holds like `s`.

## Operation
- State machine with three states, IDLE, RUN and DONE (2-bit encoding):
  - IDLE: if `start`=1, latch `a`→opA, `b`→opB, `ci`→carry, clear nibble counter, clear `s` and `co`, go to RUN. Otherwise stay in IDLE.
  - RUN: drive `cla4` with opA[3:0], opB[3:0] and carry.
    - Register the `cla4` carry-out into carry.
    - Shift `s` right by 4 with the `cla4` sum entering at `s[WIDTH-1:WIDTH-4]`.
    - Shift opA and opB right by 4 and increment the counter.
    - When the counter equals N−1 at the edge, also load `co` ← `cla4` carry-out and go to DONE.
  - DONE: `done`=1 for one cycle.
    - If `start`=1, accept as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- `start` while RUN is ignored; operand inputs are don't-care outside an accepting edge.
- Result: {`co`,`s`} = `a` + `b` + `ci` modulo 2^(WIDTH+1), unsigned, bit-exact.
- Counter width is clog2(N), minimum 1 bit. It must not wrap before N nibbles are processed.
- Reset (any time, including mid-RUN): state IDLE, `s`=0, `co`=0, `busy`=0, `done`=0, carry=0, counter=0.
  - An in-flight operation is discarded and no `done` is issued for it.

## Timing
- Accepting edge E0 (start=1 in IDLE/DONE). RUN occupies edges E1..EN, one nibble per edge.
- `busy`=1 from after E0 until after EN. `done`=1 from after EN until after EN+1.
- Latency from accepting edge to `done` visible: N cycles. With WIDTH=16, `done` is high in the 4th cycle after E0.
- Throughput with back-to-back starts: one result every N+1 cycles.
- `s` and `co` are partial and must not be used while `busy`=1. They are valid and stable whenever `done`=1 and in IDLE afterwards.
- Carry path is registered between nibbles. The critical path is one `cla4` plus shift-register setup.

## Configuration
- `NSA_SUB_EN` defined:
  - Adds port `op_sub`.
  - On accept with `op_sub`=1: opB ← ~`b` and carry ← 1, ignoring `ci`. Result is `a` − `b`.
  - `co`=1 means no borrow.
  - With `op_sub`=0, behaviour is identical to the undefined case.
- `NSA_SUB_EN` undefined: no `op_sub` port; addition only.

## Structure
- Shared package/include `nsa_pkg`: state encodings `NSA_IDLE`=2'd0, `NSA_RUN`=2'd1, `NSA_DONE`=2'd2, and the nibble width constant `NSA_NIB`=4.
- One sub-module: `cla4`, instantiated once, combinational, carry-in from the carry register.
- No other hierarchy.

## Test plan
All scenarios use WIDTH=16.
- Reset: hold `reset_n`=0 → `s`=0, `co`=0, `busy`=0, `done`=0. Release, idle 5 cycles → all outputs stay 0.
- Full carry ripple: `a`=16'hFFFF, `b`=16'h0001, `ci`=0, start → `done` after 4 cycles, `s`=16'h0000, `co`=1, `busy` high exactly 4 cycles.
- Carry-in: `a`=16'h1234, `b`=16'h4321, `ci`=1 → `s`=16'h5556, `co`=0. Then 3 idle cycles → `s` holds 16'h5556.
- Back-to-back plus ignored start:
  - Start at E0, pulse `start` again mid-RUN → ignored.
  - Start held high at the `done` cycle with `a`=16'h8000, `b`=16'h8000 → second result `s`=16'h0000, `co`=1, `done` 5 cycles after the first `done`.
- Reset mid-operation: assert `reset_n`=0 two cycles after start → no `done`, outputs 0. Next start with `a`=16'h00FF, `b`=16'h0001 → `s`=16'h0100.
- `NSA_SUB_EN`:
  - `a`=16'h0005, `b`=16'h0003, `op_sub`=1 → `s`=16'h0002, `co`=1.
  - `a`=16'h0003, `b`=16'h0005 → `s`=16'hFFFE, `co`=0.
